// File: rtl/ram_responder.sv
// ram_responder: RAM-side responder for the ram_bus single-port protocol.
// One request at a time, fixed per-operation busy latency, block-RAM backed.
module ram_responder #(
    parameter int AW     = 10,
    parameter int WR_LAT = 5,
    parameter int RD_LAT = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [22:0] addr,
    input  logic        rw,
    input  logic [31:0] data_in,
    input  logic        in_valid,
    output logic        busy,
    output logic [31:0] data_out,
    output logic        out_valid,
    output logic        overrun
);

    localparam int MAXL = (WR_LAT > RD_LAT) ? WR_LAT : RD_LAT;
    localparam int CW   = ($clog2(MAXL) < 1) ? 1 : $clog2(MAXL);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_WR,
        WAIT_RD
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [31:0]     mem [0:(1<<AW)-1];
    logic [31:0]     hold;
    logic [AW-1:0]   idx;
    logic            accept;
    logic            unused_hi;

    assign idx       = addr[AW-1:0];
    assign accept    = in_valid & ~busy & ~rst;
    assign unused_hi = ^addr[22:AW];

    // Array port: commit writes and latch read word at the accepting edge.
    always_ff @(posedge clk) begin
        if (accept && rw) begin
            mem[idx] <= data_in;
        end
        if (accept && !rw) begin
            hold <= mem[idx];
        end
    end

    // Request FSM: latency counting, read-data handoff and sticky overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            data_out  <= '0;
            overrun   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (in_valid && busy) begin
                overrun <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        busy <= 1'b1;
                        if (rw) begin
                            state <= WAIT_WR;
                            cnt   <= CW'(WR_LAT - 1);
                        end else begin
                            state <= WAIT_RD;
                            cnt   <= CW'(RD_LAT - 1);
                        end
                    end
                end
                WAIT_WR, WAIT_RD: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (state == WAIT_RD) begin
                            out_valid <= 1'b1;
                            data_out  <= hold;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_responder.sv
// tb_ram_responder: directed and random checks of ram_responder
// against a transaction-level reference model.
module tb_ram_responder;

    localparam int AW     = 10;
    localparam int WR_LAT = 5;
    localparam int RD_LAT = 9;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [22:0] addr = '0;
    logic        rw = 1'b0;
    logic [31:0] data_in = '0;
    logic        in_valid = 1'b0;
    logic        busy;
    logic [31:0] data_out;
    logic        out_valid;
    logic        overrun;

    int n_pass  = 0;
    int n_total = 0;

    // reference model state
    logic [31:0] mmem [0:(1<<AW)-1];
    int          rem;
    bit          pend_rd;
    logic [31:0] pend_data;
    logic [31:0] exp_dout;
    bit          exp_ov;
    bit          exp_ovr;

    ram_responder #(
        .AW(AW),
        .WR_LAT(WR_LAT),
        .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .addr(addr),
        .rw(rw),
        .data_in(data_in),
        .in_valid(in_valid),
        .busy(busy),
        .data_out(data_out),
        .out_valid(out_valid),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t",
                      tag, got, exp, $time);
    endtask

    task automatic model_reset();
        rem      = 0;
        pend_rd  = 0;
        exp_dout = '0;
        exp_ov   = 0;
        exp_ovr  = 0;
    endtask

    // one clock edge of the model, using the inputs held across it
    task automatic model_edge();
        bit was_busy;
        was_busy = (rem > 0);
        if (rst) begin
            model_reset();
        end else begin
            exp_ov = 0;
            if (was_busy) begin
                if (in_valid) exp_ovr = 1;
                rem--;
                if (rem == 0 && pend_rd) begin
                    exp_ov   = 1;
                    exp_dout = pend_data;
                    pend_rd  = 0;
                end
            end else if (in_valid) begin
                rem = rw ? WR_LAT : RD_LAT;
                if (rw) begin
                    mmem[addr[AW-1:0]] = data_in;
                end else begin
                    pend_rd   = 1;
                    pend_data = mmem[addr[AW-1:0]];
                end
            end
        end
    endtask

    task automatic step(input bit v, input bit w, input logic [22:0] a,
                        input logic [31:0] d, input bit r);
        @(negedge clk);
        chk("busy", 32'(busy), 32'(rem > 0));
        chk("out_valid", 32'(out_valid), 32'(exp_ov));
        chk("data_out", data_out, exp_dout);
        chk("overrun", 32'(overrun), 32'(exp_ovr));
        in_valid = v;
        rw       = w;
        addr     = a;
        data_in  = d;
        rst      = r;
        @(posedge clk);
        model_edge();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0);
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (rem > 0 && guard < 100) begin
            step(0, 0, '0, '0, 0);
            guard++;
        end
        chk("idle_timeout", 32'(rem > 0), 32'(0));
    endtask

    initial begin
        logic [22:0] a;
        model_reset();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);

        // prefill words 0..15 so every later read is defined
        for (int i = 0; i < 16; i++) begin
            step(1, 1, 23'(i), $urandom, 0);
            wait_idle();
        end
        idle(2);

        // 1: write A=5
        step(1, 1, 23'hA, 32'h5, 0);
        wait_idle();
        // 2: read A
        step(1, 0, 23'hA, '0, 0);
        wait_idle();
        idle(3);
        chk("t2_data", data_out, 32'h5);

        // 3: back-to-back write B then read B
        step(1, 1, 23'hB, 32'h4, 0);
        wait_idle();
        step(1, 0, 23'hB, '0, 0);
        wait_idle();
        idle(2);
        chk("t3_data", data_out, 32'h4);

        // 4: write C during a read -> dropped, overrun set
        step(1, 0, 23'hA, '0, 0);
        idle(2);
        step(1, 1, 23'hC, 32'h3, 0);
        wait_idle();
        idle(1);
        step(1, 0, 23'hC, '0, 0);
        wait_idle();
        idle(2);
        chk("t4_overrun", 32'(overrun), 32'(1));

        // 5: aliasing write 0x400, read 0
        step(1, 1, 23'h400, 32'hDEAD, 0);
        wait_idle();
        step(1, 0, 23'h0, '0, 0);
        wait_idle();
        idle(2);
        chk("t5_alias", data_out, 32'hDEAD);

        // 6: reset during 4th busy cycle of a read
        step(1, 0, 23'h1, '0, 0);
        idle(3);
        step(0, 0, '0, '0, 1);
        idle(12);
        step(1, 0, 23'h2, '0, 0);
        wait_idle();
        idle(2);

        // random traffic with occasional resets and overlaps
        for (int i = 0; i < 1500; i++) begin
            a = {13'($urandom), 6'b0, 4'($urandom)};
            step(($urandom_range(0, 2) == 0), 1'($urandom), a,
                 $urandom, ($urandom_range(0, 99) < 2));
        end
        wait_idle();
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
